power_switch_sequencer: RTL and testbench
=========================================

# power_switch_sequencer

Domain-side responder to the power domain controller: turns each domain's power-enable/isolation request into a staggered switch-chain sequence, bounding rush current. Only one domain ramps at a time. Reports power-good and drives domain reset per domain, and flags power-down requests that arrive without isolation. Sits between the power domain controller outputs and the header-switch chains of each core/AI/L2 domain.

## Interface
- NUM_DOMAINS, 4, number of switched domains
- NUM_STAGES, 4, switch segments per domain chain (≥2)
- STAGE_DELAY, 8, cycles between consecutive segment transitions (≥1)
- SETTLE_CYCLES, 16, cycles from last segment on to power-good (≥1)

- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- domain_power_enable  input  NUM_DOMAINS  requested power state per domain (1 = on)
- domain_isolation_enable  input  NUM_DOMAINS  isolation clamps asserted by controller
- switch_enable  output  NUM_DOMAINS*NUM_STAGES  segment enables; domain d stage s at bit d*NUM_STAGES+s
- domain_power_good  output  NUM_DOMAINS  domain fully powered and settled
- domain_reset_n  output  NUM_DOMAINS  active-low reset into domain logic
- isolation_violation  output  NUM_DOMAINS  sticky: power-down requested without isolation
- sequencer_busy  output  1  a domain is ramping or settling

## Operation
- Reset values: switch_enable all 1, domain_power_good all 1, domain_reset_n all 1, isolation_violation 0, sequencer_busy 0, all domains ON, RR pointer 0.
- Per-domain states: OFF, RAMP_UP, SETTLE, ON, RAMP_DOWN. One shared stage/settle counter; width $clog2(max(STAGE_DELAY,SETTLE_CYCLES)+1).
- Pending up: domain OFF and enable=1. Pending down: domain ON, enable=0, isolation=1.
- ON with enable=0 and isolation=0: no transition; isolation_violation[d] set (sticky until reset); domain waits until isolation=1.
- Arbitration: when no domain is in RAMP_UP/SETTLE/RAMP_DOWN, grant the first pending domain at or after RR pointer; pointer becomes granted+1 (mod NUM_DOMAINS). Up and down requests are treated alike.
- RAMP_UP: stage 0 on at grant edge; stage k on STAGE_DELAY edges after stage k-1. After stage NUM_STAGES-1, enter SETTLE.
- SETTLE: SETTLE_CYCLES edges after last stage on, power_good=1 and state ON; domain_reset_n=1 one edge later.
- RAMP_DOWN: at grant edge power_good=0 and domain_reset_n=0; stage NUM_STAGES-1 off one edge later; each lower stage off STAGE_DELAY edges after the previous; state OFF at the edge stage 0 turns off.
- Request changes mid-transition are ignored; the transition runs to completion, then the domain re-evaluates as pending.
- Reset mid-sequence restores reset values at the next edge (all switches on); no partial state kept.

## Timing
- Power-up, grant at edge G: stage s on at G+s*STAGE_DELAY; power_good at G+(NUM_STAGES-1)*STAGE_DELAY+SETTLE_CYCLES (defaults: G+40); domain_reset_n at G+41.
- Power-down, grant at edge G: power_good/reset_n low at G; stage s off at G+1+(NUM_STAGES-1-s)*STAGE_DELAY; OFF at G+25 (defaults).
- sequencer_busy high from grant edge through completion edge inclusive; next grant no earlier than completion edge +1.
- Violation flag set on the first edge the condition is sampled.
- Never more than one domain with switch_enable changing in any STAGE_DELAY window.

## Test plan
- Reset: hold rst_n=0 3 cycles, enables=1 -> switch_enable=16'hFFFF, power_good=4'hF, reset_n=4'hF, violation=0, busy=0.
- Down/up domain 0: isolation[0]=1 then enable[0]=0 at G -> power_good[0]=0 at G, bits 3,2,1,0 off at G+1,+9,+17,+25; re-enable -> bit0 at G',bit3 at G'+24, power_good[0] at G'+40, reset_n[0] at G'+41.
- Violation: enable[1]=0 with isolation[1]=0 for 10 cycles -> violation[1]=1, switch bits 7:4 stay 1; then isolation[1]=1 -> ramp-down starts, violation stays 1.
- Contention: domains 1 and 2 request down same edge -> domain 1 granted first, domain 2 granted the edge after domain 1 reaches OFF; no overlap of switch transitions.
- Abort ignored: enable[0] returns to 1 at G+5 during ramp-down -> ramp-down completes at G+25, ramp-up granted G+26.
- Mid-ramp reset: rst_n=0 at G+12 of a power-up -> next edge all outputs at reset values, busy=0.

Source files
------------

// File: rtl/power_switch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : power_switch_sequencer
//  Purpose  : Staggers header-switch segment enables per power domain, one
//             domain ramping at a time, with power-good and domain reset.
//  Revision : 1.0 - initial release
// ============================================================================
module power_switch_sequencer #(
    parameter int NUM_DOMAINS   = 4,
    parameter int NUM_STAGES    = 4,
    parameter int STAGE_DELAY   = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_DOMAINS-1:0]            domain_power_enable,
    input  logic [NUM_DOMAINS-1:0]            domain_isolation_enable,
    output logic [NUM_DOMAINS*NUM_STAGES-1:0] switch_enable,
    output logic [NUM_DOMAINS-1:0]            domain_power_good,
    output logic [NUM_DOMAINS-1:0]            domain_reset_n,
    output logic [NUM_DOMAINS-1:0]            isolation_violation,
    output logic                              sequencer_busy
);

    localparam int c_MAXD = (STAGE_DELAY > SETTLE_CYCLES) ? STAGE_DELAY : SETTLE_CYCLES;
    localparam int c_CW   = $clog2(c_MAXD + 1);
    localparam int c_SW   = $clog2(NUM_STAGES);
    localparam int c_DW   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int c_DW1  = c_DW + 1;

    localparam logic [2:0] c_OFF       = 3'd0;
    localparam logic [2:0] c_RAMP_UP   = 3'd1;
    localparam logic [2:0] c_SETTLE    = 3'd2;
    localparam logic [2:0] c_ON        = 3'd3;
    localparam logic [2:0] c_RAMP_DOWN = 3'd4;

    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_STAGE  = c_CW'(STAGE_DELAY);
    localparam logic [c_CW-1:0] c_CNT_SETTLE = c_CW'(SETTLE_CYCLES);
    localparam logic [c_SW-1:0] c_LAST       = c_SW'(NUM_STAGES - 1);
    localparam logic [c_SW-1:0] c_PENULT     = c_SW'(NUM_STAGES - 2);
    localparam logic [c_DW-1:0] c_DLAST      = c_DW'(NUM_DOMAINS - 1);
    localparam logic [c_DW:0]   c_NDX        = c_DW1'(NUM_DOMAINS);

    logic [NUM_DOMAINS-1:0][2:0]            r_state, w_state;
    logic [NUM_DOMAINS-1:0][NUM_STAGES-1:0] r_sw, w_sw;
    logic [NUM_DOMAINS-1:0]                 r_pg, w_pg;
    logic [NUM_DOMAINS-1:0]                 r_rstn, w_rstn;
    logic [NUM_DOMAINS-1:0]                 r_viol, w_viol;
    logic                                   r_busy, w_busy;
    logic                                   r_act, w_act;
    logic [c_DW-1:0]                        r_dom, w_dom;
    logic [c_DW-1:0]                        r_ptr, w_ptr;
    logic [c_CW-1:0]                        r_cnt, w_cnt;
    logic [c_SW-1:0]                        r_stage, w_stage;
    logic [NUM_DOMAINS-1:0]                 w_pend;
    logic                                   w_found;
    logic [c_DW-1:0]                        w_gnt;
    logic [c_DW:0]                          w_idx;

    always_comb begin : p_next
        w_state = r_state;
        w_sw    = r_sw;
        w_pg    = r_pg;
        w_rstn  = r_rstn;
        w_viol  = r_viol;
        w_busy  = r_act;
        w_act   = r_act;
        w_dom   = r_dom;
        w_ptr   = r_ptr;
        w_cnt   = r_cnt;
        w_stage = r_stage;
        w_pend  = '0;
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;

        for (int d = 0; d < NUM_DOMAINS; d++) begin
            w_pend[d] = ((r_state[d] == c_OFF) && domain_power_enable[d]) ||
                        ((r_state[d] == c_ON) && !domain_power_enable[d] &&
                         domain_isolation_enable[d]);
            if ((r_state[d] == c_ON) && !domain_power_enable[d] && !domain_isolation_enable[d])
                w_viol[d] = 1'b1;
            // Reset release trails power-good by one edge.
            if (r_state[d] == c_ON)
                w_rstn[d] = 1'b1;
        end

        for (int i = 0; i < NUM_DOMAINS; i++) begin
            w_idx = {1'b0, r_ptr} + c_DW1'(i);
            if (w_idx >= c_NDX)
                w_idx = w_idx - c_NDX;
            if (!w_found && w_pend[w_idx[c_DW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[c_DW-1:0];
            end
        end

        if (!r_act) begin
            if (w_found) begin
                w_act  = 1'b1;
                w_busy = 1'b1;
                w_dom  = w_gnt;
                w_ptr  = (w_gnt == c_DLAST) ? '0 : w_gnt + 1'b1;
                if (r_state[w_gnt] == c_OFF) begin
                    w_state[w_gnt]    = c_RAMP_UP;
                    w_sw[w_gnt][0]    = 1'b1;
                    w_stage           = '0;
                    w_cnt             = c_CNT_STAGE;
                end else begin
                    w_state[w_gnt] = c_RAMP_DOWN;
                    w_pg[w_gnt]    = 1'b0;
                    w_rstn[w_gnt]  = 1'b0;
                    w_stage        = c_LAST;
                    w_cnt          = c_CNT_ONE;
                end
            end
        end else if (r_cnt != c_CNT_ONE) begin
            w_cnt = r_cnt - 1'b1;
        end else begin
            case (r_state[r_dom])
                c_RAMP_UP: begin
                    w_stage               = r_stage + 1'b1;
                    w_sw[r_dom][w_stage]  = 1'b1;
                    if (r_stage == c_PENULT) begin
                        w_state[r_dom] = c_SETTLE;
                        w_cnt          = c_CNT_SETTLE;
                    end else begin
                        w_cnt = c_CNT_STAGE;
                    end
                end
                c_SETTLE: begin
                    w_state[r_dom] = c_ON;
                    w_pg[r_dom]    = 1'b1;
                    w_act          = 1'b0;
                end
                c_RAMP_DOWN: begin
                    w_sw[r_dom][r_stage] = 1'b0;
                    if (r_stage == '0) begin
                        w_state[r_dom] = c_OFF;
                        w_act          = 1'b0;
                    end else begin
                        w_stage = r_stage - 1'b1;
                        w_cnt   = c_CNT_STAGE;
                    end
                end
                default: w_act = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= {NUM_DOMAINS{c_ON}};
            r_sw    <= '1;
            r_pg    <= '1;
            r_rstn  <= '1;
            r_viol  <= '0;
            r_busy  <= 1'b0;
            r_act   <= 1'b0;
            r_dom   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_stage <= '0;
        end else begin
            r_state <= w_state;
            r_sw    <= w_sw;
            r_pg    <= w_pg;
            r_rstn  <= w_rstn;
            r_viol  <= w_viol;
            r_busy  <= w_busy;
            r_act   <= w_act;
            r_dom   <= w_dom;
            r_ptr   <= w_ptr;
            r_cnt   <= w_cnt;
            r_stage <= w_stage;
        end
    end

    assign switch_enable       = r_sw;
    assign domain_power_good   = r_pg;
    assign domain_reset_n      = r_rstn;
    assign isolation_violation = r_viol;
    assign sequencer_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_power_switch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_power_switch_sequencer
//  Purpose  : Directed vector table plus hand-timed sequences for the
//             power switch sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_power_switch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  en;
    logic [3:0]  iso;
    logic [15:0] switch_enable;
    logic [3:0]  domain_power_good;
    logic [3:0]  domain_reset_n;
    logic [3:0]  isolation_violation;
    logic        sequencer_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  iso;
        int          ticks;
        logic [15:0] sw;
        logic [3:0]  pg;
        logic [3:0]  rn;
        logic [3:0]  viol;
        logic        busy;
    } vec_t;

    vec_t tbl [15];

    power_switch_sequencer dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .domain_power_enable     (en),
        .domain_isolation_enable (iso),
        .switch_enable           (switch_enable),
        .domain_power_good       (domain_power_good),
        .domain_reset_n          (domain_reset_n),
        .isolation_violation     (isolation_violation),
        .sequencer_busy          (sequencer_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] sw, input logic [3:0] pg,
                             input logic [3:0] rn, input logic [3:0] viol, input logic busy);
        chk({tag, ".sw"},   32'(switch_enable),       32'(sw));
        chk({tag, ".pg"},   32'(domain_power_good),   32'(pg));
        chk({tag, ".rstn"}, 32'(domain_reset_n),      32'(rn));
        chk({tag, ".viol"}, 32'(isolation_violation), 32'(viol));
        chk({tag, ".busy"}, 32'(sequencer_busy),      32'(busy));
    endtask

    // Switch activity from more than one domain on a single edge is never legal.
    logic [15:0] prev_sw = 16'hFFFF;
    logic        mon_rst;
    int          nchg;
    always @(posedge clk) begin
        mon_rst = rst_n;
        #1;
        if (mon_rst) begin
            nchg = 0;
            for (int d = 0; d < 4; d++)
                if (switch_enable[d*4 +: 4] != prev_sw[d*4 +: 4]) nchg++;
            if (nchg > 0) begin
                total++;
                if (nchg > 1) begin
                    bad++;
                    $display("FAIL overlap: got %0d domains switching expected 1", nchg);
                end
            end
        end
        prev_sw = switch_enable;
    end

    initial begin
        // Domain 0 power-down then power-up, grant edge G is the first edge of vec1.
        tbl[0]  = '{4'hF, 4'h1,  1, 16'hFFFF, 4'hF, 4'hF, 4'h0, 1'b0};
        tbl[1]  = '{4'hE, 4'h1,  1, 16'hFFFF, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[2]  = '{4'hE, 4'h1,  1, 16'hFFF7, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[3]  = '{4'hE, 4'h1,  7, 16'hFFF7, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[4]  = '{4'hE, 4'h1,  1, 16'hFFF3, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[5]  = '{4'hE, 4'h1,  8, 16'hFFF1, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[6]  = '{4'hE, 4'h1,  7, 16'hFFF1, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[7]  = '{4'hE, 4'h1,  1, 16'hFFF0, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[8]  = '{4'hE, 4'h1,  1, 16'hFFF0, 4'hE, 4'hE, 4'h0, 1'b0};
        tbl[9]  = '{4'hF, 4'h1,  1, 16'hFFF1, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[10] = '{4'hF, 4'h1,  8, 16'hFFF3, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[11] = '{4'hF, 4'h1, 16, 16'hFFFF, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[12] = '{4'hF, 4'h1, 15, 16'hFFFF, 4'hE, 4'hE, 4'h0, 1'b1};
        tbl[13] = '{4'hF, 4'h1,  1, 16'hFFFF, 4'hF, 4'hE, 4'h0, 1'b1};
        tbl[14] = '{4'hF, 4'h1,  1, 16'hFFFF, 4'hF, 4'hF, 4'h0, 1'b0};

        rst_n = 1'b0;
        en    = 4'hF;
        iso   = 4'h0;
        tick(3);
        check_all("reset", 16'hFFFF, 4'hF, 4'hF, 4'h0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            en  = tbl[i].en;
            iso = tbl[i].iso;
            tick(tbl[i].ticks);
            check_all($sformatf("vec%0d", i), tbl[i].sw, tbl[i].pg, tbl[i].rn,
                      tbl[i].viol, tbl[i].busy);
        end

        // Power-down of domain 1 without isolation.
        en  = 4'hD;
        iso = 4'h1;
        tick(1);
        check_all("viol_first", 16'hFFFF, 4'hF, 4'hF, 4'h2, 1'b0);
        tick(9);
        check_all("viol_hold", 16'hFFFF, 4'hF, 4'hF, 4'h2, 1'b0);
        iso = 4'h2;
        tick(1);
        check_all("viol_grant", 16'hFFFF, 4'hD, 4'hD, 4'h2, 1'b1);
        tick(1);
        check_all("viol_s3off", 16'hFF7F, 4'hD, 4'hD, 4'h2, 1'b1);
        tick(24);
        check_all("viol_off", 16'hFF0F, 4'hD, 4'hD, 4'h2, 1'b1);
        tick(1);
        check_all("viol_idle", 16'hFF0F, 4'hD, 4'hD, 4'h2, 1'b0);
        en = 4'hF;
        tick(42);
        check_all("viol_up", 16'hFFFF, 4'hF, 4'hF, 4'h2, 1'b0);

        // Request flips back mid ramp-down; the ramp-down still completes.
        en  = 4'hE;
        iso = 4'h1;
        tick(1);
        check_all("abort_grant", 16'hFFFF, 4'hE, 4'hE, 4'h2, 1'b1);
        tick(4);
        en = 4'hF;
        tick(1);
        check_all("abort_g5", 16'hFFF7, 4'hE, 4'hE, 4'h2, 1'b1);
        tick(20);
        check_all("abort_off", 16'hFFF0, 4'hE, 4'hE, 4'h2, 1'b1);
        tick(1);
        check_all("abort_regrant", 16'hFFF1, 4'hE, 4'hE, 4'h2, 1'b1);
        tick(11);
        check_all("midramp", 16'hFFF3, 4'hE, 4'hE, 4'h2, 1'b1);
        rst_n = 1'b0;
        tick(1);
        check_all("midramp_rst", 16'hFFFF, 4'hF, 4'hF, 4'h0, 1'b0);
        rst_n = 1'b1;

        // Domains 1 and 2 request power-down on the same edge.
        en  = 4'h9;
        iso = 4'h6;
        tick(1);
        check_all("cont_grant1", 16'hFFFF, 4'hD, 4'hD, 4'h0, 1'b1);
        tick(25);
        check_all("cont_off1", 16'hFF0F, 4'hD, 4'hD, 4'h0, 1'b1);
        tick(1);
        check_all("cont_grant2", 16'hFF0F, 4'h9, 4'h9, 4'h0, 1'b1);
        tick(1);
        check_all("cont_s3off2", 16'hF70F, 4'h9, 4'h9, 4'h0, 1'b1);
        tick(24);
        check_all("cont_off2", 16'hF00F, 4'h9, 4'h9, 4'h0, 1'b1);
        tick(1);
        check_all("cont_idle", 16'hF00F, 4'h9, 4'h9, 4'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
